// File: rtl/coin_payer_if.sv
// Coin-bus bundle between coin_payer (master) and the dispenser side (slave).
// Carries the payment request, the coin stream, dispenser responses and tallies.
interface coin_payer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [4:0]       amount;
  logic             cancel;
  logic             drink;
  logic [1:0]       back;
  logic [1:0]       coin;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] drinks;
  logic [5:0]       change;
  logic [4:0]       spent;

  modport master (
    input  start, amount, cancel, drink, back,
    output coin, busy, done, drinks, change, spent
  );

  modport slave (
    output start, amount, cancel, drink, back,
    input  coin, busy, done, drinks, change, spent
  );
endinterface

// File: rtl/coin_payer.sv
// Customer-side coin bus driver: pays an amount greedily in 10c/5c coins, requests
// a refund, then tallies the dispenser's drink/back responses for the transaction.
module coin_payer #(
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  coin_payer_if.master  bus
);

  typedef enum logic [2:0] {IDLE, SEND, REFUND, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic [1:0]       coin_q, coin_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;
  logic [4:0]       rem_q, rem_nx;
  logic [4:0]       spent_q, spent_nx;
  logic [CNT_W-1:0] drinks_q, drinks_nx;
  logic [5:0]       change_q, change_nx;
  logic [4:0]       pay_src;
  logic [1:0]       pay_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [5:0] sat_add6(input logic [5:0] v, input logic [1:0] d);
    logic [6:0] s;
    s = {1'b0, v} + {5'b0, d};
    return s[6] ? 6'd63 : s[5:0];
  endfunction

  // Largest coin not exceeding what is still owed.
  function automatic logic [1:0] greedy(input logic [4:0] r);
    return (r >= 5'd2) ? 2'd2 : {1'b0, r[0]};
  endfunction

  // The registered coin belongs to the current state, so the next coin is chosen
  // one cycle ahead: from amount when starting, from remaining while sending.
  assign pay_src = (state == IDLE) ? bus.amount : rem_q;
  assign pay_c   = greedy(pay_src);

  always_comb begin
    state_nx  = state;
    coin_nx   = coin_q;
    busy_nx   = busy_q;
    done_nx   = 1'b0;
    rem_nx    = rem_q;
    spent_nx  = spent_q;
    drinks_nx = drinks_q;
    change_nx = change_q;

    if (busy_q) begin
      if (bus.drink) drinks_nx = sat_inc(drinks_q);
      change_nx = sat_add6(change_q, bus.back);
    end

    case (state)
      IDLE: begin
        coin_nx = 2'd0;
        if (bus.start && (bus.amount != 5'd0)) begin
          coin_nx   = pay_c;
          rem_nx    = bus.amount - {3'b0, pay_c};
          spent_nx  = {3'b0, pay_c};
          drinks_nx = '0;
          change_nx = 6'd0;
          busy_nx   = 1'b1;
          state_nx  = SEND;
        end
      end
      SEND: begin
        if (bus.cancel || (rem_q == 5'd0)) begin
          coin_nx  = 2'd3;
          rem_nx   = 5'd0;
          state_nx = REFUND;
        end else begin
          coin_nx  = pay_c;
          rem_nx   = rem_q - {3'b0, pay_c};
          spent_nx = spent_q + {3'b0, pay_c};
        end
      end
      REFUND: begin
        coin_nx  = 2'd0;
        state_nx = DRAIN;
      end
      DRAIN: begin
        coin_nx  = 2'd0;
        busy_nx  = 1'b0;
        done_nx  = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        coin_nx  = 2'd0;
        state_nx = IDLE;
      end
      default: begin
        coin_nx  = 2'd0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      coin_q   <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rem_q    <= 5'd0;
      spent_q  <= 5'd0;
      drinks_q <= '0;
      change_q <= 6'd0;
    end else begin
      state    <= state_nx;
      coin_q   <= coin_nx;
      busy_q   <= busy_nx;
      done_q   <= done_nx;
      rem_q    <= rem_nx;
      spent_q  <= spent_nx;
      drinks_q <= drinks_nx;
      change_q <= change_nx;
    end
  end

  assign bus.coin   = coin_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.drinks = drinks_q;
  assign bus.change = change_q;
  assign bus.spent  = spent_q;

endmodule

// File: tb/tb_coin_payer.sv
// Bench for coin_payer: a 20c dispenser model answers the coin stream; table vectors,
// hand sequences and random transactions are checked against arithmetic expectations.
module tb_coin_payer;
  localparam int CNT_W = 4;
  localparam int DMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coin_payer_if #(.CNT_W(CNT_W)) bus();
  coin_payer #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Dispenser: 4 units buy a drink; a refund returns all held credit.
  int         credit;
  logic       d_drink;
  logic [1:0] d_back;
  bit         noise_on = 1'b0;
  logic       n_drink = 1'b0;
  logic [1:0] n_back = 2'd0;

  function automatic int add_coin(input int cr, input logic [1:0] c);
    return (c == 2'd1) ? cr + 1 : (c == 2'd2) ? cr + 2 : (c == 2'd3) ? 0 : cr;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit  <= 0;
      d_drink <= 1'b0;
      d_back  <= 2'd0;
    end else begin
      d_back  <= (bus.coin == 2'd3) ? credit[1:0] : 2'd0;
      d_drink <= (add_coin(credit, bus.coin) >= 4);
      credit  <= (add_coin(credit, bus.coin) >= 4) ? add_coin(credit, bus.coin) - 4
                                                    : add_coin(credit, bus.coin);
    end
  end

  assign bus.drink = noise_on ? n_drink : d_drink;
  assign bus.back  = noise_on ? n_back  : d_back;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: payment cycles and the coin expected at busy-cycle j (0-based).
  function automatic int n_pay_f(input int a, input int c);
    int nf;
    nf = (a + 1) / 2;
    return (c != 0 && c < nf) ? c : nf;
  endfunction

  function automatic int coin_at(input int a, input int c, input int j);
    int np;
    np = n_pay_f(a, c);
    if (j < np) return (2 * (j + 1) <= a) ? 2 : 1;
    if (j == np) return 3;
    return 0;
  endfunction

  logic [1:0] seq[$];

  task automatic run_txn(input string nm, input int a, input int c, input int poke,
                         input bit noise, input bit all_drink, input int e_drinks,
                         input int e_change, input int e_spent, input int e_busy);
    int sd, sb, bz, r_d, r_c, r_s, ed, ec;
    bit got;
    sd = 0; sb = 0; bz = 0; got = 1'b0; r_d = 0; r_c = 0; r_s = 0;
    seq.delete();
    noise_on = noise;
    @(posedge clk); #1;
    check({nm, "_idle_done"}, bus.done, 0);
    bus.start  = 1'b1;
    bus.amount = a[4:0];
    n_drink    = 1'($urandom_range(0, 1));
    n_back     = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (bus.done) begin
        got = 1'b1;
        r_d = int'(bus.drinks);
        r_c = int'(bus.change);
        r_s = int'(bus.spent);
        check({nm, "_busy_at_done"}, bus.busy, 0);
      end else begin
        if (bus.busy) begin
          bz++;
          seq.push_back(bus.coin);
        end
        bus.cancel = (i == c);
        bus.start  = (i == poke);
        bus.amount = (i == poke) ? 5'd9 : a[4:0];
        n_drink    = all_drink ? 1'b1 : 1'($urandom_range(0, 1));
        n_back     = 2'($urandom_range(0, 3));
        if (i <= e_busy) begin
          sd += int'(n_drink);
          sb += int'(n_back);
        end
        @(posedge clk); #1;
      end
    end
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
    ed = noise ? ((sd > DMAX) ? DMAX : sd) : e_drinks;
    ec = noise ? ((sb > 63) ? 63 : sb) : e_change;
    check({nm, "_done_seen"}, got, 1);
    check({nm, "_drinks"}, r_d, ed);
    check({nm, "_change"}, r_c, ec);
    check({nm, "_spent"}, r_s, e_spent);
    check({nm, "_busy_cycles"}, bz, e_busy);
    check({nm, "_seq_len"}, seq.size(), e_busy);
    for (int j = 0; j < seq.size(); j++)
      check($sformatf("%s_coin%0d", nm, j), int'(seq[j]), coin_at(a, c, j));
  endtask

  typedef struct {
    int amount;
    int cancel_at;
    int poke_at;
    int e_drinks;
    int e_change;
    int e_spent;
    int e_busy;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4,  0, 0, 1, 0, 4,  4};
    vecs[1] = '{5,  0, 0, 1, 1, 5,  5};
    vecs[2] = '{3,  0, 0, 0, 3, 3,  4};
    vecs[3] = '{6,  0, 0, 1, 2, 6,  5};
    vecs[4] = '{8,  2, 0, 1, 0, 4,  4};
    vecs[5] = '{31, 0, 0, 7, 3, 31, 18};
    vecs[6] = '{6,  0, 2, 1, 2, 6,  5};
    vecs[7] = '{1,  0, 0, 0, 1, 1,  3};
    vecs[8] = '{7,  5, 0, 1, 3, 7,  6};

    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.amount = 5'd0;
    bus.cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_coin", bus.coin, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_drinks", bus.drinks, 0);
    check("rst_change", bus.change, 0);
    check("rst_spent", bus.spent, 0);
    reset = 1'b1;

    foreach (vecs[k])
      run_txn($sformatf("vec%0d", k), vecs[k].amount, vecs[k].cancel_at, vecs[k].poke_at,
              1'b0, 1'b0, vecs[k].e_drinks, vecs[k].e_change, vecs[k].e_spent,
              vecs[k].e_busy);

    // Start held through DONE is only taken in the following IDLE cycle.
    noise_on   = 1'b0;
    bus.start  = 1'b1;
    bus.amount = 5'd2;
    @(posedge clk); #1;
    check("b2b_idle_busy", bus.busy, 0);
    check("b2b_idle_coin", bus.coin, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_busy", bus.busy, 1);
    check("b2b_coin", bus.coin, 2);
    for (int i = 0; i < 10 && !bus.done; i++) begin
      @(posedge clk); #1;
    end
    check("b2b_done", bus.done, 1);
    check("b2b_change", bus.change, 2);
    check("b2b_spent", bus.spent, 2);

    // Zero amount is not a transaction.
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.amount = 5'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("zero_busy", bus.busy, 0);
    check("zero_coin", bus.coin, 0);
    @(posedge clk); #1;
    check("zero_busy2", bus.busy, 0);

    // Drink count saturates when every busy cycle reports a drink.
    run_txn("sat", 31, 0, 0, 1'b1, 1'b1, 0, 0, 31, 18);

    for (int r = 0; r < 24; r++) begin
      int a, c, np;
      a  = $urandom_range(1, 31);
      c  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 17) : 0;
      np = n_pay_f(a, c);
      run_txn($sformatf("rnd%0d", r), a, c, 0, 1'($urandom_range(0, 1)), 1'b0,
              ((2 * np < a) ? 2 * np : a) / 4, ((2 * np < a) ? 2 * np : a) % 4,
              (2 * np < a) ? 2 * np : a, np + 2);
    end

    // Asynchronous reset in the middle of SEND.
    noise_on = 1'b0;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.amount = 5'd12;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("mid_spent_before", bus.spent, 4);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_coin", bus.coin, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_spent", bus.spent, 0);
    check("mid_rst_drinks", bus.drinks, 0);
    check("mid_rst_change", bus.change, 0);
    #2 reset = 1'b1;
    run_txn("after_rst", 2, 0, 0, 1'b0, 1'b0, 0, 2, 2, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/coin_payer.md
# coin_payer

Customer-side driver for the vending-machine coin bus. Given a payment amount in 5-cent units, it feeds coins one per cycle on the `coin` bus, then issues a refund code to recover any leftover credit. It tallies the machine's `drink`/`back` responses into per-transaction counters. It sits opposite the drink dispenser and serves as its stimulus source in system benches.

## Interface
- `CNT_W`, default 4: width of the `drinks` counter; saturates at 2^CNT_W-1.
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-low; clears all state and outputs immediately.
- `start`  in  1  — begin transaction; sampled only in IDLE.
- `amount`  in  5  — payment in 5-cent units (0..31); latched on accepted `start`.
- `cancel`  in  1  — abandon remaining payment; sampled only in SEND.
- `drink`  in  1  — dispenser response, registered on the dispenser side.
- `back`  in  2  — dispenser change response, in 5-cent units.
- `coin`  out  2  — registered coin code: 0 none, 1 = 5c, 2 = 10c, 3 = refund request.
- `busy`  out  1  — high from the cycle after `start` is accepted through DRAIN.
- `done`  out  1  — one-cycle pulse; counters are final in this cycle.
- `drinks`  out  CNT_W  — drinks received this transaction.
- `change`  out  6  — sum of `back` this transaction; saturates at 63.
- `spent`  out  5  — units actually inserted; excludes amounts abandoned by cancel.

## Operation
- States: IDLE, SEND, REFUND, DRAIN, DONE.
- Reset values: state IDLE, `coin`=0, `busy`=0, `done`=0, `drinks`=0, `change`=0, `spent`=0, remaining=0.
- IDLE:
  - `start`=1 and `amount`≠0: latch remaining=`amount`, clear all counters, go to SEND.
  - `start` with `amount`=0: ignored.
- SEND: one coin per cycle, greedy.
  - remaining≥2: `coin`=2, remaining−=2, `spent`+=2.
  - remaining=1: `coin`=1, remaining=0, `spent`+=1.
  - When the coin just issued brings remaining to 0, go to REFUND.
- `cancel`=1 in SEND takes priority over payment: no payment coin is issued that cycle, remaining is discarded, go to REFUND.
- REFUND: `coin`=3 for exactly one cycle, go to DRAIN.
  - Always issued, even when no credit is left. The dispenser answers a refund at zero credit with `back`=0.
- DRAIN: `coin`=0 for one cycle to collect the response to the refund, go to DONE.
- DONE: `done`=1, `busy`=0, `coin`=0, go to IDLE.
  - Counters hold their values until the next accepted `start`.
- Response accumulation, in every cycle with `busy`=1:
  - `drink`=1: `drinks`+=1, saturating.
  - `change`+=`back`, saturating at 63.
- Ignored inputs:
  - `start` when not in IDLE.
  - `cancel` outside SEND.
  - `drink`/`back` while `busy`=0.
- Arithmetic: remaining is 5 bits, `spent` is 5 bits; `spent` can never exceed `amount`.

## Timing
- Latency from start: `start` sampled at edge E0 → first coin on `coin` in the cycle after E0.
- Coin stream: coins occupy consecutive cycles with no gaps; the number of payment cycles is ceil(amount/2).
- Response alignment, for a coin driven in cycle C:
  - The dispenser samples it at the end of C and drives its response in cycle C+1.
  - coin_payer samples that response at the end of C+1.
- Refund response: for the refund in cycle R, DRAIN is cycle R+1 and `done` asserts in cycle R+2 with final counters.
- Total transaction: `busy` lasts ceil(amount/2)+2 cycles, and `done` follows in the next cycle.
- Cancel latency: `cancel` sampled at the end of SEND cycle k → `coin`=3 in cycle k+1.
  - The coin driven in cycle k still counts in `spent`.
- Back-to-back: a `start` held high during DONE is not accepted. The earliest accepted `start` is sampled in the IDLE cycle after DONE.
- Reset mid-transaction:
  - `coin` drops to 0 asynchronously, with no refund issued.
  - All counters clear.
  - Machine-side credit is the dispenser's own responsibility.

## Test plan
- Exact payment: `amount`=4 → `coin` 2,2,3,0.
  - `drink` pulses after the second 2.
  - At `done`: `drinks`=1, `change`=0, `spent`=4; `busy` high for 4 cycles.
- Partial coin: `amount`=5 → `coin` 2,2,1,3.
  - At `done`: `drinks`=1, `change`=1, `spent`=5.
- Short of price: `amount`=3 → `coin` 2,1,3 (dispenser reaches 15c).
  - At `done`: `drinks`=0, `change`=3.
  - Repeat with `amount`=6 → `drinks`=1, `change`=2.
- Cancel: `amount`=8, `cancel` pulsed in the second SEND cycle → `coin` 2,2,3.
  - At `done`: `spent`=4, `drinks`=1, `change`=0.
- Ignored inputs:
  - `start` with `amount`=0 → `busy` stays 0.
  - `start` pulsed while `busy` → no effect; the current counters complete normally.
  - `amount`=31 → 16 coins, `drinks`=7, `change`=3, `spent`=31.
- Reset mid-SEND: assert `reset` low between edges → `coin`, `busy` and counters go to 0 immediately.
  - After release, a new `start` with `amount`=2 completes: `coin` 2,3; `change`=2.
